// File: rtl/paged_memory_pkg.sv
// Shared types for paged_memory: memory operation and pointer operation encodings,
// plus the pointer-select width helper used by the top and the pointer file.
package paged_memory_pkg;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_READ,
        OP_WRITE,
        OP_FETCH
    } mem_op_e;

    typedef enum logic [2:0] {
        PTR_NONE,
        PTR_REL_SUB,
        PTR_REL_ADD,
        PTR_INC,
        PTR_ABSOLUTE
    } ptr_op_e;

    function automatic int ptr_sel_width(input int num_ptr);
        return (num_ptr > 1) ? $clog2(num_ptr) : 1;
    endfunction

endpackage

// File: rtl/paged_memory_pointer_file.sv
// Address pointer registers with relative/absolute arithmetic (modulo 2**ADDR_W).
// Optional sticky overflow flag built only when MEMORY_PTR_FAULT_EN is defined.
module paged_memory_pointer_file
    import paged_memory_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int NUM_PTR = 2,
    localparam int SEL_W  = ptr_sel_width(NUM_PTR)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              apply,
    input  logic [SEL_W-1:0]  ptr_sel,
    input  ptr_op_e           ptr_op,
    input  logic [DATA_W-1:0] operand,
    output logic [ADDR_W-1:0] ptr_cur,
    output logic              fault
);

    logic [ADDR_W-1:0] ptr_q [NUM_PTR];
    logic [ADDR_W-1:0] operand_a;
    logic [ADDR_W-1:0] ptr_next;

    // Reducing the operand modulo 2**ADDR_W first leaves the wrapped result unchanged.
    assign operand_a = ADDR_W'(operand);

    always_comb begin
        ptr_cur = '0;
        for (int i = 0; i < NUM_PTR; i++) begin
            if (ptr_sel == SEL_W'(i)) ptr_cur = ptr_q[i];
        end
    end

    always_comb begin
        ptr_next = ptr_cur;
        case (ptr_op)
            PTR_REL_ADD:  ptr_next = ptr_cur + operand_a;
            PTR_REL_SUB:  ptr_next = ptr_cur - operand_a;
            PTR_INC:      ptr_next = ptr_cur + ADDR_W'(1);
            PTR_ABSOLUTE: ptr_next = operand_a;
            default:      ptr_next = ptr_cur;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PTR; i++) ptr_q[i] <= '0;
        end else if (apply) begin
            for (int i = 0; i < NUM_PTR; i++) begin
                if (ptr_sel == SEL_W'(i)) ptr_q[i] <= ptr_next;
            end
        end
    end

`ifdef MEMORY_PTR_FAULT_EN
    localparam int OW = ((DATA_W > ADDR_W) ? DATA_W : ADDR_W) + 1;

    logic [OW-1:0] sum_ext;
    logic          overflow;

    // Full-width sum so any operand bits above ADDR_W also count as carry-out.
    assign sum_ext = OW'(ptr_cur) + OW'(operand);

    always_comb begin
        overflow = 1'b0;
        case (ptr_op)
            PTR_REL_ADD: overflow = (sum_ext >> ADDR_W) != '0;
            PTR_REL_SUB: overflow = OW'(operand) > OW'(ptr_cur);
            PTR_INC:     overflow = &ptr_cur;
            default:     overflow = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (apply && overflow) begin
            fault <= 1'b1;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: rtl/paged_memory.sv
// Paged word memory behind a pointer file, with READ/WRITE and a streaming line FETCH.
// Define MEMORY_PTR_FAULT_EN to build the sticky pointer-overflow fault flag.
module paged_memory
    import paged_memory_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int WORD_SEL_W = 1,
    parameter int NUM_PTR    = 2,
    localparam int SEL_W     = ptr_sel_width(NUM_PTR)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     in,
    output logic [DATA_W-1:0]     out,
    output logic                  out_valid,
    input  logic [SEL_W-1:0]      ptr_sel,
    input  logic [WORD_SEL_W-1:0] word_sel,
    input  mem_op_e               op,
    input  ptr_op_e               ptr_op,
    output logic                  busy,
    output logic                  fault,
    output logic                  state_dbg
);

    localparam int MEM_AW = ADDR_W + WORD_SEL_W;

    typedef enum logic {IDLE, STREAM} state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     ptr_cur;
    logic [ADDR_W-1:0]     line_q;
    logic [WORD_SEL_W-1:0] cnt_q;
    logic [DATA_W-1:0]     mem [2**MEM_AW];
    logic [DATA_W-1:0]     rd_data_q;
    logic [MEM_AW-1:0]     addr;
    logic                  idle;
    logic                  do_read;
    logic                  do_write;

    paged_memory_pointer_file #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_PTR (NUM_PTR)
    ) u_pointer_file (
        .clock   (clock),
        .reset   (reset),
        .apply   (idle),
        .ptr_sel (ptr_sel),
        .ptr_op  (ptr_op),
        .operand (in),
        .ptr_cur (ptr_cur),
        .fault   (fault)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (op == OP_FETCH) state_d = STREAM;
            STREAM:  if (&cnt_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // While streaming, every cycle reads the latched line and all inputs are ignored.
    always_comb begin
        idle      = (state_q == IDLE);
        busy      = (state_q == STREAM);
        state_dbg = (state_q == STREAM);
        addr      = idle ? {ptr_cur, word_sel} : {line_q, cnt_q};
        do_read   = idle ? (op == OP_READ) : 1'b1;
        do_write  = idle && (op == OP_WRITE) && !reset;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else if (idle) begin
            cnt_q <= '0;
            if (op == OP_FETCH) line_q <= ptr_cur;
        end else begin
            cnt_q <= cnt_q + WORD_SEL_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q <= '0;
            out_valid <= 1'b0;
        end else begin
            rd_data_q <= do_read ? mem[addr] : '0;
            out_valid <= do_read;
        end
    end

    always_ff @(posedge clock) begin
        if (do_write) mem[addr] <= in;
    end

    assign out = rd_data_q;

endmodule

// File: tb/tb_paged_memory.sv
// Scoreboard bench for paged_memory: random and directed ops against an array/queue
// reference model; a negedge monitor checks words, their arrival cycle, busy and fault.
module tb_paged_memory;
    import paged_memory_pkg::*;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 8;
    localparam int WORD_SEL_W = 1;
    localparam int NUM_PTR    = 2;
    localparam int SEL_W      = ptr_sel_width(NUM_PTR);
    localparam int LINE_WORDS = 2**WORD_SEL_W;
    localparam int PTR_MOD    = 2**ADDR_W;
    localparam int MEM_WORDS  = 2**(ADDR_W + WORD_SEL_W);
`ifdef MEMORY_PTR_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [DATA_W-1:0]     in = '0;
    logic [DATA_W-1:0]     out;
    logic                  out_valid;
    logic [SEL_W-1:0]      ptr_sel = '0;
    logic [WORD_SEL_W-1:0] word_sel = '0;
    mem_op_e               op = OP_NOP;
    ptr_op_e               ptr_op = PTR_NONE;
    logic                  busy;
    logic                  fault;
    logic                  state_dbg;

    paged_memory #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .WORD_SEL_W (WORD_SEL_W),
        .NUM_PTR    (NUM_PTR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in        (in),
        .out       (out),
        .out_valid (out_valid),
        .ptr_sel   (ptr_sel),
        .word_sel  (word_sel),
        .op        (op),
        .ptr_op    (ptr_op),
        .busy      (busy),
        .fault     (fault),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    int                m_ptr [NUM_PTR];
    int                m_mem [MEM_WORDS];
    bit                m_fault = 1'b0;
    int                fetch_t = -100;
    logic [DATA_W-1:0] exp_q[$];
    int                exp_t_q[$];

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    bit done = 1'b0;

    // ---------------- driver tasks ----------------
    task automatic step(input mem_op_e o, input ptr_op_e po, input int sel,
                        input int wsel, input int data);
        int e;
        int base;
        int v;
        op       = o;
        ptr_op   = po;
        ptr_sel  = SEL_W'(sel);
        word_sel = WORD_SEL_W'(wsel);
        in       = DATA_W'(data);
        e = cyc + 1;
        @(posedge clock);
        if (!(e > fetch_t && e <= fetch_t + LINE_WORDS)) begin
            base = m_ptr[sel] * LINE_WORDS;
            case (o)
                OP_READ: begin
                    exp_q.push_back(DATA_W'(m_mem[base + wsel]));
                    exp_t_q.push_back(e);
                end
                OP_WRITE: m_mem[base + wsel] = data;
                OP_FETCH: begin
                    fetch_t = e;
                    for (int i = 0; i < LINE_WORDS; i++) begin
                        exp_q.push_back(DATA_W'(m_mem[base + i]));
                        exp_t_q.push_back(e + 1 + i);
                    end
                end
                default: ;
            endcase
            case (po)
                PTR_REL_ADD:  v = m_ptr[sel] + data;
                PTR_REL_SUB:  v = m_ptr[sel] - data;
                PTR_INC:      v = m_ptr[sel] + 1;
                PTR_ABSOLUTE: v = data % PTR_MOD;
                default:      v = m_ptr[sel];
            endcase
            if (FAULT_EN && (v < 0 || v >= PTR_MOD)) m_fault = 1'b1;
            m_ptr[sel] = ((v % PTR_MOD) + PTR_MOD) % PTR_MOD;
        end
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        op     = OP_NOP;
        ptr_op = PTR_NONE;
        @(posedge clock);
        for (int i = 0; i < NUM_PTR; i++) m_ptr[i] = 0;
        m_fault = 1'b0;
        fetch_t = -100;
        exp_q.delete();
        exp_t_q.delete();
        #1;
        reset = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endfunction

    always @(negedge clock) begin
        if (done) begin
            check("leftover_words", exp_q.size(), 0);
        end else if (mon_en) begin
            check("busy", busy, (cyc >= fetch_t && cyc < fetch_t + LINE_WORDS));
            check("fault", fault, m_fault);
            while (exp_t_q.size() > 0 && exp_t_q[0] < cyc) begin
                check("missing_word_cycle", cyc, exp_t_q[0]);
                void'(exp_t_q.pop_front());
                void'(exp_q.pop_front());
            end
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", out_valid, 0);
                end else begin
                    check("word_cycle", cyc, exp_t_q.pop_front());
                    check("word_data", out, exp_q.pop_front());
                end
            end else begin
                check("out_valid", out_valid, (exp_t_q.size() > 0 && exp_t_q[0] == cyc));
                check("out_zero_when_invalid", out, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        mon_en = 1'b1;

        // Fill every line through ptr0; the final INC wraps 0xFF -> 0x00.
        for (int l = 0; l < PTR_MOD; l++) begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                step(OP_WRITE, (w == LINE_WORDS - 1) ? PTR_INC : PTR_NONE, 0, w,
                     $urandom_range(0, 255));
            end
        end
        do_reset();

        // Write then read back immediately.
        step(OP_WRITE, PTR_NONE, 0, 1, 'hA5);
        step(OP_READ, PTR_NONE, 0, 1, 0);

        // Pointer arithmetic on ptr1, ptr0 left alone.
        step(OP_NOP, PTR_ABSOLUTE, 1, 0, 'h10);
        step(OP_NOP, PTR_INC, 1, 0, 0);
        step(OP_NOP, PTR_REL_ADD, 1, 0, 'h05);
        step(OP_NOP, PTR_REL_SUB, 1, 0, 'h03);
        step(OP_WRITE, PTR_NONE, 1, 0, 'h3C);
        step(OP_READ, PTR_NONE, 0, 1, 0);
        step(OP_NOP, PTR_ABSOLUTE, 0, 0, 'h13);
        step(OP_READ, PTR_NONE, 0, 0, 0);

        // Wrap boundaries.
        step(OP_NOP, PTR_ABSOLUTE, 0, 0, 'hFF);
        step(OP_READ, PTR_INC, 0, 0, 0);
        step(OP_READ, PTR_NONE, 0, 0, 0);
        do_reset();
        step(OP_NOP, PTR_REL_SUB, 0, 0, 1);
        step(OP_READ, PTR_NONE, 0, 1, 0);
        step(OP_NOP, PTR_ABSOLUTE, 1, 0, 'hF0);
        step(OP_NOP, PTR_REL_ADD, 1, 0, 'h20);
        step(OP_READ, PTR_NONE, 1, 1, 0);
        do_reset();

        // FETCH of a preloaded line with writes issued mid-stream.
        step(OP_NOP, PTR_ABSOLUTE, 1, 0, 'h20);
        step(OP_WRITE, PTR_NONE, 1, 0, 'h11);
        step(OP_WRITE, PTR_NONE, 1, 1, 'h22);
        step(OP_FETCH, PTR_NONE, 1, 0, 0);
        step(OP_WRITE, PTR_INC, 1, 0, 'h99);
        step(OP_WRITE, PTR_INC, 1, 1, 'h99);
        step(OP_READ, PTR_NONE, 1, 0, 0);
        step(OP_FETCH, PTR_INC, 1, 0, 0);
        step(OP_NOP, PTR_NONE, 0, 0, 0);
        step(OP_NOP, PTR_NONE, 0, 0, 0);
        step(OP_READ, PTR_NONE, 1, 0, 0);

        // READ with INC on the same edge uses the old address.
        step(OP_NOP, PTR_ABSOLUTE, 0, 0, 'h40);
        step(OP_READ, PTR_INC, 0, 1, 0);
        step(OP_READ, PTR_NONE, 0, 1, 0);

        // Reset in the first streaming cycle.
        step(OP_FETCH, PTR_NONE, 1, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) step(OP_NOP, PTR_NONE, 0, 0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                step(mem_op_e'($urandom_range(0, 3)), ptr_op_e'($urandom_range(0, 4)),
                     $urandom_range(0, NUM_PTR - 1), $urandom_range(0, LINE_WORDS - 1),
                     $urandom_range(0, 255));
            end
        end
        for (int i = 0; i < LINE_WORDS + 3; i++) step(OP_NOP, PTR_NONE, 0, 0, 0);

        done = 1'b1;
        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
